// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci job dispatcher: FSM state encoding
// and default watchdog / cycle-counter sizing.
package fib_pkg;

  // Default watchdog limit in RUN cycles and default cycle-count width.
  localparam int unsigned FIB_TIMEOUT_DEF = 4095;
  localparam int unsigned FIB_CYC_W_DEF   = 16;

  typedef enum logic [1:0] {
    FIB_IDLE   = 2'd0,
    FIB_LAUNCH = 2'd1,
    FIB_RUN    = 2'd2,
    FIB_HOLD   = 2'd3
  } fib_state_e;

endpackage : fib_pkg

// File: rtl/fib_dispatch.sv
// Dispatcher between a valid/ready job stream and an external Fibonacci
// compute core. One job in flight: operands are registered, the core is
// strobed, its done flag is watched under a watchdog, and the result is
// held for downstream until accepted.
//
//   state  | meaning
//   IDLE   | ready for a job; core held in load
//   LAUNCH | new operands stable, core loads them (one cycle)
//   RUN    | core computing; cycle counter and watchdog running
//   HOLD   | response presented until rsp_ready
module fib_dispatch
  import fib_pkg::*;
#(
  parameter int unsigned TIMEOUT = FIB_TIMEOUT_DEF,
  parameter int unsigned CYC_W   = FIB_CYC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_n,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic             core_r_enable,
  output logic [5:0]       core_init_n,
  output logic [31:0]      core_init_a,
  output logic [31:0]      core_init_b,
  input  logic             core_w_enable,
  input  logic [31:0]      core_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [CYC_W-1:0] rsp_cycles,
  output logic             rsp_timeout
);

  localparam logic [1:0] S_IDLE   = FIB_IDLE;
  localparam logic [1:0] S_LAUNCH = FIB_LAUNCH;
  localparam logic [1:0] S_RUN    = FIB_RUN;
  localparam logic [1:0] S_HOLD   = FIB_HOLD;

  // TIMEOUT is expected to fit in CYC_W bits.
  localparam logic [CYC_W-1:0] TO_VAL = CYC_W'(TIMEOUT);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CYC_W-1:0] cyc_cnt;
  logic [CYC_W-1:0] cyc_inc;
  logic             run_done;
  logic             run_to;

  // Handshake and core strobe are pure functions of state, so neither ready
  // nor valid ever depends combinationally on the opposite side.
  assign req_ready     = (state == S_IDLE);
  assign rsp_valid     = (state == S_HOLD);
  assign core_r_enable = (state != S_RUN);

  // Count of RUN cycles including the current one, saturating at all-ones.
  always_comb begin
    cyc_inc = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CYC_W'(1);
  end

  // Done is only meaningful in RUN; it wins over a coincident watchdog hit.
  assign run_done = (state == S_RUN) && core_w_enable;
  assign run_to   = (state == S_RUN) && !core_w_enable && (cyc_inc == TO_VAL);

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_RUN;
      S_RUN:    if (run_done || run_to) state_nxt = S_HOLD;
      S_HOLD:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register; reset drops any job in flight without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // RUN-cycle counter: cleared in LAUNCH, advanced every RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if (state == S_LAUNCH) begin
      cyc_cnt <= '0;
    end else if (state == S_RUN) begin
      cyc_cnt <= cyc_inc;
    end
  end

  // Job operands change only when a job is accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_init_n <= '0;
      core_init_a <= '0;
      core_init_b <= '0;
    end else if ((state == S_IDLE) && req_valid) begin
      core_init_n <= req_n;
      core_init_a <= req_a;
      core_init_b <= req_b;
    end
  end

  // Response capture on done or watchdog; held untouched through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data    <= '0;
      rsp_cycles  <= '0;
      rsp_timeout <= 1'b0;
    end else if (run_done) begin
      rsp_data    <= core_result;
      rsp_cycles  <= cyc_inc;
      rsp_timeout <= 1'b0;
    end else if (run_to) begin
      rsp_data    <= '0;
      rsp_cycles  <= TO_VAL;
      rsp_timeout <= 1'b1;
    end
  end

endmodule : fib_dispatch

// File: tb/tb_fib_dispatch.sv
// Directed bench for fib_dispatch with a behavioural compute core.
// Core model: loads operands while core_r_enable=1; in RUN it performs n
// steps of (x,y) <= (x+y, x) and raises a sticky done flag in RUN cycle n+6,
// returning x. An override path lets the bench drive done/result directly.
module tb_fib_dispatch;

  localparam int unsigned TO = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [5:0]    req_n;
  logic [31:0]   req_a;
  logic [31:0]   req_b;
  logic          core_r_enable;
  logic [5:0]    core_init_n;
  logic [31:0]   core_init_a;
  logic [31:0]   core_init_b;
  logic          core_w_enable;
  logic [31:0]   core_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic [CW-1:0] rsp_cycles;
  logic          rsp_timeout;

  logic          ovr_en;
  logic          ovr_done;
  logic [31:0]   ovr_result;

  logic [31:0]   m_x;
  logic [31:0]   m_y;
  int            m_k;
  logic          m_done;

  int n_chk  = 0;
  int n_pass = 0;

  fib_dispatch #(.TIMEOUT(TO), .CYC_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_n         (req_n),
    .req_a         (req_a),
    .req_b         (req_b),
    .core_r_enable (core_r_enable),
    .core_init_n   (core_init_n),
    .core_init_a   (core_init_a),
    .core_init_b   (core_init_b),
    .core_w_enable (core_w_enable),
    .core_result   (core_result),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_cycles    (rsp_cycles),
    .rsp_timeout   (rsp_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural core (no reset, like the real one).
  always @(posedge clk) begin
    if (core_r_enable) begin
      m_k    <= 0;
      m_x    <= core_init_a;
      m_y    <= core_init_b;
      m_done <= 1'b0;
    end else if (!m_done) begin
      if (m_k < int'(core_init_n)) begin
        m_x <= m_x + m_y;
        m_y <= m_x;
      end
      if (m_k == int'(core_init_n) + 4) m_done <= 1'b1;
      m_k <= m_k + 1;
    end
  end

  assign core_w_enable = ovr_en ? ovr_done   : m_done;
  assign core_result   = ovr_en ? ovr_result : m_x;

  typedef struct {
    logic [5:0]  n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_to;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a job for one accepting edge; returns with the DUT in LAUNCH.
  task automatic send(input logic [5:0] n, input logic [31:0] a, input logic [31:0] b);
    req_n = n; req_a = a; req_b = b; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Waits for rsp_valid; lat counts edges since the accepting edge.
  task automatic wait_rsp(inout int lat);
    while (!rsp_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_rsp(input string nm, input logic [31:0] d, input logic to, input int cyc);
    chk({nm, "_valid"},   32'(rsp_valid),   32'd1);
    chk({nm, "_data"},    rsp_data,         d);
    chk({nm, "_timeout"}, 32'(rsp_timeout), 32'(to));
    chk({nm, "_cycles"},  32'(rsp_cycles),  32'(cyc));
  endtask

  task automatic release_rsp(input string nm);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({nm, "_post_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_post_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run_job(input string nm, input logic [5:0] n, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] d, input logic to,
                         input int cyc);
    int lat;
    chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
    send(n, a, b);
    lat = 1;
    wait_rsp(lat);
    chk({nm, "_latency"}, 32'(lat), 32'(cyc + 2));
    check_rsp(nm, d, to, cyc);
    release_rsp(nm);
  endtask

  initial begin
    int lat;
    logic ok;

    vecs[0] = '{6'd0, 32'd5,          32'd7, 32'd5,          1'b0, 6};
    vecs[1] = '{6'd1, 32'd1,          32'd1, 32'd2,          1'b0, 7};
    vecs[2] = '{6'd2, 32'd1,          32'd1, 32'd3,          1'b0, 8};  // done meets watchdog
    vecs[3] = '{6'd3, 32'd1,          32'd1, 32'd0,          1'b1, 8};  // watchdog first
    vecs[4] = '{6'd0, 32'hDEADBEEF,   32'd0, 32'hDEADBEEF,   1'b0, 6};
    vecs[5] = '{6'd1, 32'hFFFFFFFF,   32'd2, 32'd1,          1'b0, 7};

    rst_n = 1'b0; req_valid = 1'b0; req_n = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0; ovr_en = 1'b0; ovr_done = 1'b0; ovr_result = '0;
    tick(); tick();

    chk("rst_req_ready",   32'(req_ready),     32'd1);
    chk("rst_core_r_en",   32'(core_r_enable), 32'd1);
    chk("rst_init_n",      32'(core_init_n),   32'd0);
    chk("rst_init_a",      core_init_a,        32'd0);
    chk("rst_init_b",      core_init_b,        32'd0);
    chk("rst_rsp_valid",   32'(rsp_valid),     32'd0);
    chk("rst_rsp_data",    rsp_data,           32'd0);
    chk("rst_rsp_cycles",  32'(rsp_cycles),    32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout),   32'd0);

    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_job($sformatf("vec%0d", i), vecs[i].n, vecs[i].a, vecs[i].b,
              vecs[i].exp_data, vecs[i].exp_to, vecs[i].exp_cyc);
    end

    // Backpressure in HOLD with another job waiting upstream.
    req_n = 6'd0; req_a = 32'd5; req_b = 32'd7; req_valid = 1'b1;
    tick();
    req_n = 6'd1; req_a = 32'd1; req_b = 32'd1;
    lat = 1;
    wait_rsp(lat);
    check_rsp("bp_first", 32'd5, 1'b0, 6);
    for (int i = 0; i < 20; i++) begin
      ok = !req_ready && rsp_valid && rsp_data == 32'd5 && rsp_cycles == CW'(6) &&
           !rsp_timeout && core_init_n == 6'd0 && core_init_a == 32'd5 && core_r_enable;
      chk($sformatf("bp_hold_stable%0d", i), 32'(ok), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
    tick();
    req_valid = 1'b0;
    chk("bp_next_accepted", 32'(req_ready), 32'd0);
    chk("bp_next_init_n",   32'(core_init_n), 32'd1);
    chk("bp_next_init_b",   core_init_b, 32'd1);
    lat = 1;
    wait_rsp(lat);
    chk("bp_next_latency", 32'(lat), 32'd9);
    check_rsp("bp_next", 32'd2, 1'b0, 7);
    release_rsp("bp_next");

    // Core that never finishes: watchdog response.
    ovr_en = 1'b1; ovr_done = 1'b0; ovr_result = 32'h55AA55AA;
    run_job("stuck", 6'd4, 32'd9, 32'd9, 32'd0, 1'b1, 8);

    // Done flag asserted in IDLE and LAUNCH is ignored; taken in RUN.
    ovr_done = 1'b1; ovr_result = 32'h0000AAAA;
    tick(); tick();
    chk("glitch_idle_ready", 32'(req_ready), 32'd1);
    send(6'd5, 32'd3, 32'd4);
    chk("glitch_launch_r_en", 32'(core_r_enable), 32'd1);
    tick();
    chk("glitch_run_valid", 32'(rsp_valid), 32'd0);
    chk("glitch_run_r_en",  32'(core_r_enable), 32'd0);
    ovr_result = 32'h00001234;
    tick();
    check_rsp("glitch", 32'h00001234, 1'b0, 1);
    release_rsp("glitch");
    ovr_en = 1'b0; ovr_done = 1'b0;

    // Reset during RUN discards the job.
    send(6'd0, 32'd5, 32'd7);
    tick(); tick(); tick();
    chk("mid_in_run", 32'(core_r_enable), 32'd0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_req_ready", 32'(req_ready),     32'd1);
    chk("mid_rst_r_en",      32'(core_r_enable), 32'd1);
    chk("mid_rst_valid",     32'(rsp_valid),     32'd0);
    chk("mid_rst_init_a",    core_init_a,        32'd0);
    chk("mid_rst_data",      rsp_data,           32'd0);
    chk("mid_rst_cycles",    32'(rsp_cycles),    32'd0);
    tick();
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid || !req_ready) ok = 1'b0;
    end
    chk("mid_no_response", 32'(ok), 32'd1);
    run_job("after_rst", 6'd1, 32'd1, 32'd1, 32'd2, 1'b0, 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_fib_dispatch
